// File: rtl/multu_unit.sv
// multu_unit: multi-cycle unsigned shift-add multiplier with HI/LO result
// registers. The multiply takes a fixed WIDTH cycles. While it runs, the unit
// stalls the core if HI/LO is read or another multiply is issued.
module multu_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             hilo_rd,
   output logic             busy,
   output logic             done,
   output logic             stall,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state, state_nxt;
   logic [WIDTH-1:0] mcand;
   logic [WIDTH-1:0] acc;
   logic [WIDTH-1:0] mplier;
   logic [CW-1:0]    cnt;
   logic [WIDTH:0]   sum;
   logic             launch;
   logic             last_step;

   // One shift-add step: add the multiplicand when the multiplier LSB is set.
   // The carry lands in bit WIDTH and is shifted back into the acc MSB.
   always_comb begin
      sum       = {1'b0, acc} + (mplier[0] ? {1'b0, mcand} : '0);
      // A start seen in RUN is ignored; it is accepted in IDLE and DONE.
      launch    = start && (state != RUN);
      last_step = (state == RUN) && (cnt == CNT_ONE);
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // Next-state logic; DONE with start relaunches for back-to-back issue.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    state_nxt = start ? RUN : IDLE;
         RUN:     state_nxt = (cnt == CNT_ONE) ? DONE : RUN;
         DONE:    state_nxt = start ? RUN : IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Outputs decoded from the state; stall freezes decode while a product is pending.
   always_comb begin
      busy  = (state == RUN);
      done  = (state == DONE);
      stall = (state == RUN) && (hilo_rd || start);
   end

   // Operand latch and shift-add datapath; {acc,mplier} shifts right one bit per step.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mcand  <= '0;
         acc    <= '0;
         mplier <= '0;
         cnt    <= '0;
      end else if (launch) begin
         mcand  <= a;
         acc    <= '0;
         mplier <= b;
         cnt    <= CNT_INIT;
      end else if (state == RUN) begin
         acc    <= sum[WIDTH:1];
         mplier <= {sum[0], mplier[WIDTH-1:1]};
         cnt    <= cnt - CNT_ONE;
      end
   end

   // HI/LO capture the result of the final step and hold otherwise.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hi <= '0;
         lo <= '0;
      end else if (last_step) begin
         hi <= sum[WIDTH:1];
         lo <= {sum[0], mplier[WIDTH-1:1]};
      end
   end

endmodule
